// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer DAC encoder and the flash-ADC decoder top.
package thermo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SLEW = 1'b1
    } state_t;

    localparam int unsigned CODE_LSB = 0;
    localparam int unsigned LOAD_BIT = 3;
    localparam int unsigned MODE_BIT = 4;

    function automatic int unsigned t_width(input int unsigned n_bits);
        return (32'd1 << n_bits) - 32'd1;
    endfunction

endpackage

// File: rtl/bin2therm.sv
// Combinational level-to-thermometer mapper: bit i is set when level exceeds i.
module bin2therm #(
    parameter int unsigned N_BITS = 3,
    parameter int unsigned T      = 7
) (
    input  logic [N_BITS-1:0] i_level,
    output logic [T-1:0]      o_therm
);

    always_comb begin
        o_therm = '0;
        for (int unsigned i = 0; i < T; i++) begin
            o_therm[i] = (32'(i_level) > i);
        end
    end

endmodule

// File: rtl/thermo_dac_encoder.sv
// Slew-limited binary-to-thermometer encoder for the unary loopback DAC.
// Walks the output one element per step toward a loaded target, or jumps in direct mode.
module thermo_dac_encoder
    import thermo_pkg::*;
#(
    parameter int unsigned N_BITS   = 3,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [8:0] io_in,
    output logic [8:0] io_out,
    output logic [8:0] io_oeb
);

    localparam int unsigned T_W = t_width(N_BITS);

    state_t              r_state, w_state_nx;
    logic [N_BITS-1:0]   r_level, w_level_nx;
    logic [N_BITS-1:0]   r_target, w_target_nx;
    logic                r_mode, w_mode_nx;
    logic [7:0]          r_presc, w_presc_nx;
    logic                r_busy, w_busy_nx;
    logic                r_done, w_done_nx;
    logic [T_W-1:0]      r_therm;
    logic [T_W-1:0]      w_therm_nx;

    logic [N_BITS-1:0]   w_code;
    logic                w_load;
    logic                w_mode_in;
    logic                w_tick;
    logic                w_unused;

    assign w_code    = io_in[CODE_LSB +: N_BITS];
    assign w_load    = io_in[LOAD_BIT];
    assign w_mode_in = io_in[MODE_BIT];
    assign w_unused  = ^io_in[8:5];

    assign w_tick = (r_state == SLEW) && (r_presc == 8'(STEP_DIV - 1));

    always_comb begin
        w_state_nx  = r_state;
        w_level_nx  = r_level;
        w_target_nx = r_target;
        w_mode_nx   = r_mode;
        w_presc_nx  = r_presc;
        w_busy_nx   = r_busy;
        w_done_nx   = 1'b0;

        if (r_state == SLEW) begin
            w_presc_nx = w_tick ? '0 : r_presc + 8'd1;
        end

        // A load pre-empts any step or completion on the same edge.
        if (w_load) begin
            w_target_nx = w_code;
            w_mode_nx   = w_mode_in;
            w_state_nx  = SLEW;
            w_busy_nx   = 1'b1;
            if (r_state == IDLE) begin
                w_presc_nx = '0;
            end
        end else if (w_tick) begin
            if (r_level == r_target) begin
                w_state_nx = IDLE;
                w_busy_nx  = 1'b0;
                w_done_nx  = 1'b1;
            end else if (r_mode) begin
                w_level_nx = r_target;
            end else if (r_target > r_level) begin
                w_level_nx = r_level + 1'b1;
            end else begin
                w_level_nx = r_level - 1'b1;
            end
        end
    end

    // Decode the next level so the thermometer is registered alongside it.
    bin2therm #(
        .N_BITS (N_BITS),
        .T      (T_W)
    ) u_bin2therm (
        .i_level (w_level_nx),
        .o_therm (w_therm_nx)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state  <= IDLE;
            r_level  <= '0;
            r_target <= '0;
            r_mode   <= 1'b0;
            r_presc  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_therm  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_level  <= w_level_nx;
            r_target <= w_target_nx;
            r_mode   <= w_mode_nx;
            r_presc  <= w_presc_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
            r_therm  <= w_therm_nx;
        end
    end

    assign io_out = {r_done, r_busy, r_therm};
    assign io_oeb = '0;

endmodule

// File: tb/tb_thermo_dac_encoder.sv
// Scoreboard bench: two encoders (step divider 1 and 3) share stimulus and are checked
// every cycle against a level/target reference model kept in the bench.
module tb_thermo_dac_encoder;

    logic       clk;
    logic       rst;
    logic [8:0] io_in;
    logic [8:0] out1, out3;
    logic [8:0] oeb1, oeb3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int m_level[2];
    int m_target[2];
    int m_cnt[2];
    bit m_mode[2];
    bit m_slew[2];
    bit m_done[2];

    thermo_dac_encoder #(.N_BITS(3), .STEP_DIV(1)) dut1 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (out1),
        .io_oeb   (oeb1)
    );

    thermo_dac_encoder #(.N_BITS(3), .STEP_DIV(3)) dut3 (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .io_in    (io_in),
        .io_out   (out3),
        .io_oeb   (oeb3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_level[k] = 0; m_target[k] = 0; m_cnt[k] = 0;
            m_mode[k] = 0; m_slew[k] = 0; m_done[k] = 0;
        end
    endtask

    // Reference: a step is due every D-th cycle counted from slew entry.
    task automatic model_edge(input int k, input bit ld, input int code, input bit md,
                              output logic [8:0] exp);
        int d;
        d = (k == 0) ? 1 : 3;
        m_done[k] = 0;
        if (ld) begin
            m_cnt[k]    = m_slew[k] ? m_cnt[k] + 1 : 0;
            m_target[k] = code;
            m_mode[k]   = md;
            m_slew[k]   = 1;
        end else if (m_slew[k]) begin
            m_cnt[k]++;
            if (m_cnt[k] % d == 0) begin
                if (m_level[k] == m_target[k]) begin
                    m_slew[k] = 0;
                    m_done[k] = 1;
                end else if (m_mode[k]) m_level[k] = m_target[k];
                else if (m_target[k] > m_level[k]) m_level[k]++;
                else m_level[k]--;
            end
        end
        exp = {m_done[k], m_slew[k], 7'((1 << m_level[k]) - 1)};
    endtask

    task automatic step(input bit ld, input int code, input bit md);
        logic [8:0] e;
        io_in = {4'($urandom), md, ld, 3'(code)};
        model_edge(0, ld, code, md, e); q0.push_back(e);
        model_edge(1, ld, code, md, e); q1.push_back(e);
        @(posedge clk);
        #3;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!m_slew[0] && !m_slew[1]) return;
            step(0, 0, 0);
        end
        n_checks++;
        $display("FAIL wait_idle: still busy after 200 cycles, required idle");
    endtask

    task automatic step_until_level0(input int lvl);
        for (int i = 0; i < 100; i++) begin
            if (m_level[0] == lvl) return;
            step(0, 0, 0);
        end
        n_checks++;
        $display("FAIL reach_level: level %0d, required %0d", m_level[0], lvl);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                check("out_div1", out1, q0.pop_front());
                check("oeb_div1", oeb1, 9'd0);
            end
            if (q1.size() > 0) begin
                check("out_div3", out3, q1.pop_front());
                check("oeb_div3", oeb3, 9'd0);
            end
        end
    end

    initial begin
        bit done_q;
        rst   = 1'b1;
        io_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check("reset_div1", out1, 9'd0);
        check("reset_div3", out3, 9'd0);
        rst = 1'b0;
        step(0, 0, 0);

        // Slew up to 5 from 0
        step(1, 5, 0); wait_idle(); step(0, 0, 0);
        // Slew down 6 -> 1
        step(1, 6, 0); wait_idle();
        step(1, 1, 0); wait_idle(); step(0, 0, 0);
        // Direct 0 -> 7
        step(1, 0, 1); wait_idle();
        step(1, 7, 1); wait_idle(); step(0, 0, 0);
        // Retarget mid-slew, then reload on the completion edge
        step(1, 0, 0); wait_idle();
        step(1, 6, 0);
        step_until_level0(2);
        step(1, 0, 0);
        done_q = 0;
        for (int i = 0; i < 100 && !done_q; i++) begin
            if (m_slew[0] && m_level[0] == m_target[0]) begin
                step(1, 3, 0);
                done_q = 1;
            end else step(0, 0, 0);
        end
        wait_idle(); step(0, 0, 0);
        // Equal code
        step(1, 4, 0); wait_idle();
        step(1, 4, 0); wait_idle(); step(0, 0, 0);
        // Asynchronous reset mid-slew at level 4
        step(1, 0, 1); wait_idle();
        step(1, 7, 0);
        step_until_level0(4);
        rst = 1'b1;
        #1;
        check("async_rst_div1", out1, 9'd0);
        check("async_rst_div3", out3, 9'd0);
        model_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        step(0, 0, 0);

        // Randomised loads, retargets and mode changes
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0)
                step(1, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else
                step(0, 0, 0);
        end
        wait_idle();
        step(0, 0, 0);
        @(posedge clk);
        #3;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d/%0d entries left, required 0/0", q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
